// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - class codes, state/kind encodings, ALU opcodes and reset values for control_fsm
package control_pkg;

  // Instruction class codes (top three instruction bits)
  localparam logic [2:0] CLASS_NOP   = 3'b000;
  localparam logic [2:0] CLASS_ALU   = 3'b001;
  localparam logic [2:0] CLASS_CONST = 3'b010;
  localparam logic [2:0] CLASS_MEM   = 3'b100;
  localparam logic [2:0] CLASS_CTRL  = 3'b101;

  // Sub-field values that select the real operation inside a class
  localparam logic [2:0] CTRL_SUB_BEQ = 3'b001;
  localparam logic [1:0] CONST_SUB_OK = 2'b10;

  // ALU opcode constants
  localparam logic [4:0] ALUOP_ADD = 5'b00000;
  localparam logic [4:0] ALUOP_BEQ = 5'b00010;

  // Idle / reset values of the control outputs
  localparam logic RST_MEM_READ_N  = 1'b1;
  localparam logic RST_MEM_WRITE_N = 1'b1;
  localparam logic RST_CTRL        = 1'b0;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  // Resolved operation kind; folds the NOP-equivalent encodings into K_NOP
  typedef enum logic [2:0] {
    K_NOP     = 3'd0,
    K_ALU     = 3'd1,
    K_CONST   = 3'd2,
    K_LOAD    = 3'd3,
    K_STORE   = 3'd4,
    K_BEQ     = 3'd5,
    K_ILLEGAL = 3'd6
  } kind_e;

  function automatic kind_e classify(input logic [2:0] cls, input logic [2:0] sub,
                                     input logic [1:0] cst, input logic func);
    kind_e k;
    case (cls)
      CLASS_NOP:   k = K_NOP;
      CLASS_ALU:   k = K_ALU;
      CLASS_CONST: k = (cst == CONST_SUB_OK) ? K_CONST : K_NOP;
      CLASS_MEM:   k = func ? K_STORE : K_LOAD;
      CLASS_CTRL:  k = (sub == CTRL_SUB_BEQ) ? K_BEQ : K_NOP;
      default:     k = K_ILLEGAL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational class/function decode of the latched instruction
module control_decode
  import control_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int ALUOP_W = 5
) (
  input  logic [INSTR_W-1:0] instr_i,
  output kind_e              kind_o,
  output logic [ALUOP_W-1:0] alu_field_o
);

  logic [2:0] cls;
  logic [2:0] sub;
  logic [1:0] cst;
  logic       func;
  logic       unused_instr;

  assign cls  = instr_i[INSTR_W-1 -: 3];
  assign sub  = instr_i[INSTR_W-4 -: 3];
  assign cst  = instr_i[INSTR_W-7 -: 2];
  assign func = instr_i[INSTR_W-8];

  assign kind_o      = classify(cls, sub, cst, func);
  assign alu_field_o = instr_i[INSTR_W-4 -: ALUOP_W];

  // Low instruction bits carry operands that this controller does not look at
  assign unused_instr = ^instr_i;

endmodule

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multi-cycle instruction control FSM; define ILLEGAL_TRAP_EN to trap on illegal classes
module control_fsm
  import control_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int ALUOP_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic               mem_req,
  input  logic               mem_ack,
  output logic               branch,
  output logic               alu_src,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               register_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               mem_read_n,
  output logic               mem_write_n,
  output logic               update_b,
  output logic [CNT_W-1:0]   retired,
  output logic               trap
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               update_b_q, update_b_d;
  logic               retire;
  logic               in_flight;
  kind_e              kind;
  logic [ALUOP_W-1:0] alu_field;

  control_decode #(
    .INSTR_W (INSTR_W),
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .instr_i     (instr_q),
    .kind_o      (kind),
    .alu_field_o (alu_field)
  );

  // States in which the class control set (alu_src/alu_op) is presented
  assign in_flight = (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                     (state_q == ST_MEM)    || (state_q == ST_WB);

  // State and latched instruction; reset drops any in-flight access at once
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_FETCH;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // Retired-instruction counter and its toggle flag, both stepped by retire
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      retired_q  <= '0;
      update_b_q <= 1'b0;
    end else begin
      retired_q  <= retired_d;
      update_b_q <= update_b_d;
    end
  end

  assign retired_d  = retire ? retired_q + CNT_W'(1) : retired_q;
  assign update_b_d = update_b_q ^ retire;
  assign retired    = retired_q;
  assign update_b   = update_b_q;

  // Next-state, handshakes and control outputs decoded from the current state
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    retire      = 1'b0;
    instr_ready = 1'b0;
    mem_req     = RST_CTRL;
    branch      = RST_CTRL;
    alu_src     = RST_CTRL;
    mem_to_reg  = RST_CTRL;
    reg_write   = RST_CTRL;
    register_b  = RST_CTRL;
    trap        = RST_CTRL;
    alu_op      = ALUOP_W'(ALUOP_ADD);
    mem_read_n  = RST_MEM_READ_N;
    mem_write_n = RST_MEM_WRITE_N;

    if (in_flight) begin
      case (kind)
        K_ALU: alu_op = alu_field;
        K_CONST, K_LOAD, K_STORE: begin
          alu_src = 1'b1;
          alu_op  = ALUOP_W'(ALUOP_ADD);
        end
        default: alu_op = ALUOP_W'(ALUOP_ADD);
      endcase
    end

    case (state_q)
      ST_FETCH: begin
        // Ready is withheld while reset is held so no fetch can be claimed
        instr_ready = resetn;
        if (instr_valid) begin
          instr_d = instruction;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
`ifdef ILLEGAL_TRAP_EN
        if (kind == K_ILLEGAL) state_d = ST_TRAP;
`endif
      end
      ST_EXEC: begin
        case (kind)
          K_LOAD, K_STORE: state_d = ST_MEM;
          K_ALU, K_CONST:  state_d = ST_WB;
          K_BEQ: begin
            branch     = 1'b1;
            register_b = 1'b1;
            alu_op     = ALUOP_W'(ALUOP_BEQ);
            retire     = 1'b1;
            state_d    = ST_FETCH;
          end
          default: begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        if (kind == K_STORE) begin
          mem_write_n = 1'b0;
          register_b  = 1'b1;
        end else begin
          mem_read_n = 1'b0;
        end
        if (mem_ack) begin
          if (kind == K_STORE) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (kind == K_LOAD);
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        trap = 1'b1;
`else
        trap = RST_CTRL;
`endif
        state_d = ST_TRAP;
      end
      default: state_d = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - directed scoreboard bench for control_fsm
module tb_control_fsm;

  localparam int INSTR_W = 32;
  localparam int ALUOP_W = 5;
  // Narrow counter so the wrap-around is reachable in a short run
  localparam int CNT_W   = 8;

  logic               clock = 1'b0;
  logic               resetn = 1'b0;
  logic               instr_valid = 1'b0;
  logic               mem_ack = 1'b0;
  logic [INSTR_W-1:0] instruction = '0;
  logic               instr_ready, mem_req, branch, alu_src, mem_to_reg, reg_write;
  logic               register_b, mem_read_n, mem_write_n, update_b, trap;
  logic [ALUOP_W-1:0] alu_op;
  logic [CNT_W-1:0]   retired;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             upd;
  } exp_t;

  exp_t             exp_q[$];
  logic [CNT_W-1:0] model_cnt;
  logic             model_upd;
  logic             seen_upd;
  int               passed = 0;
  int               failed = 0;
  int               total  = 0;

  wire [9:0] ctrl = {mem_req, branch, alu_src, mem_to_reg, reg_write,
                     register_b, mem_read_n, mem_write_n, trap, instr_ready};

  always #5 clock = ~clock;

  control_fsm #(
    .INSTR_W (INSTR_W),
    .ALUOP_W (ALUOP_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .branch      (branch),
    .alu_src     (alu_src),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .register_b  (register_b),
    .alu_op      (alu_op),
    .mem_read_n  (mem_read_n),
    .mem_write_n (mem_write_n),
    .update_b    (update_b),
    .retired     (retired),
    .trap        (trap)
  );

  function automatic logic [9:0] cv(input logic req, input logic br, input logic src,
                                    input logic m2r, input logic rw, input logic rb,
                                    input logic rn, input logic wn, input logic tr,
                                    input logic rdy);
    return {req, br, src, m2r, rw, rb, rn, wn, tr, rdy};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    model_cnt = '0;
    model_upd = 1'b0;
    seen_upd  = 1'b0;
    exp_q.delete();
  endtask

  // Present one instruction to a DUT sitting in FETCH; returns in DECODE
  task automatic issue(input logic [INSTR_W-1:0] ins, input bit retires);
    instruction = ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instruction = $urandom;
    if (retires) begin
      model_cnt = model_cnt + 1'b1;
      model_upd = ~model_upd;
      exp_q.push_back('{cnt: model_cnt, upd: model_upd});
    end
  endtask

  // Wait (bounded) for the next retire and compare it against the scoreboard
  task automatic wait_retire(input string tag);
    exp_t e;
    logic want;
    int   n;
    n = 0;
    while (update_b === seen_upd && n < 20) begin
      tick();
      n++;
    end
    want = ~seen_upd;
    check({tag, "_retire_seen"}, update_b, want);
    seen_upd = update_b;
    check({tag, "_sb_pending"}, exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_retired"}, retired, e.cnt);
      check({tag, "_update_b"}, update_b, e.upd);
    end
  endtask

  initial begin
    logic [9:0] rst_v;
    rst_v = cv(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    model_reset();

    // Reset values
    resetn = 1'b0;
    repeat (2) tick();
    check("reset_ctrl", ctrl[9:1], rst_v[9:1]);
    check("reset_alu_op", alu_op, 0);
    check("reset_retired", retired, 0);
    check("reset_update_b", update_b, 0);
    resetn = 1'b1;
    tick();
    check("idle_ctrl", ctrl, cv(0, 0, 0, 0, 0, 0, 1, 1, 0, 1));

    // ALU add: WB in the fourth cycle, then retire
    issue(32'h2000_0000, 1);
    check("alu_decode_ctrl", ctrl, cv(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tick();
    tick();
    check("alu_wb_ctrl", ctrl, cv(0, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    check("alu_wb_op", alu_op, 5'b00000);
    wait_retire("alu_add");
    check("alu_ready_after", instr_ready, 1'b1);

    // ALU with a non-zero opcode field
    issue(32'h2B00_0000, 1);
    tick();
    check("alu_exec_op", alu_op, 5'b01011);
    wait_retire("alu_op");

    // Load with mem_ack after three MEM cycles; early mem_ack must be ignored
    issue(32'h8000_0000, 1);
    mem_ack = 1'b1;
    check("load_decode_ctrl", ctrl, cv(0, 0, 1, 0, 0, 0, 1, 1, 0, 0));
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_ack = (i == 2);
      check($sformatf("load_mem_%0d", i), ctrl, cv(1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
      tick();
    end
    mem_ack = 1'b0;
    check("load_wb_ctrl", ctrl, cv(0, 0, 1, 1, 1, 0, 1, 1, 0, 0));
    wait_retire("load");

    // Store: retires on mem_ack without a WB cycle
    issue(32'h8100_0000, 1);
    tick();
    tick();
    check("store_mem_ctrl", ctrl, cv(1, 0, 1, 0, 0, 1, 1, 0, 0, 0));
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("store_done_ctrl", ctrl, cv(0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
    wait_retire("store");

    // Beq: branch for the EXEC cycle only
    issue(32'hA400_0000, 1);
    check("beq_decode_ctrl", ctrl, cv(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tick();
    check("beq_exec_ctrl", ctrl, cv(0, 1, 0, 0, 0, 1, 1, 1, 0, 0));
    check("beq_exec_op", alu_op, 5'b00010);
    tick();
    check("beq_after_ctrl", ctrl, cv(0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
    wait_retire("beq");

    // Non-beq control transfer behaves as NOP
    issue(32'hA800_0000, 1);
    tick();
    check("ctrl_nop_exec", ctrl, cv(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    wait_retire("ctrl_nop");

    // Constant class
    issue(32'h4200_0000, 1);
    tick();
    tick();
    check("const_wb_ctrl", ctrl, cv(0, 0, 1, 0, 1, 0, 1, 1, 0, 0));
    check("const_wb_op", alu_op, 5'b00000);
    wait_retire("const");

    // Constant with wrong sub-field behaves as NOP
    issue(32'h4100_0000, 1);
    tick();
    check("const_nop_exec", ctrl, cv(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tick();
    check("const_nop_done", ctrl, cv(0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
    wait_retire("const_nop");

    // Illegal class
`ifdef ILLEGAL_TRAP_EN
    issue(32'hE000_0000, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      instr_valid = 1'b1;
      check($sformatf("trap_hold_%0d", i), ctrl, cv(0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
      tick();
    end
    instr_valid = 1'b0;
    check("trap_no_retire", update_b, seen_upd);
    resetn = 1'b0;
    tick();
    check("trap_reset_ctrl", ctrl[9:1], rst_v[9:1]);
    resetn = 1'b1;
    tick();
    model_reset();
    check("trap_cleared", ctrl, cv(0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
`else
    issue(32'hE000_0000, 1);
    tick();
    check("illegal_exec_ctrl", ctrl, cv(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    wait_retire("illegal_nop");
`endif

    // Fill the counter to all-ones, then one more NOP wraps it
    while (model_cnt != '1) begin
      issue('0, 1);
      wait_retire("nop_fill");
    end
    check("preload_all_ones", retired, 8'hFF);
    issue('0, 1);
    tick();
    check("nop_not_yet_retired", update_b, seen_upd);
    tick();
    wait_retire("nop_wrap");
    check("wrap_zero", retired, 8'h00);

    // Reset asserted mid-MEM aborts the access with no retire
    issue('0, 1);
    wait_retire("nop_post");
    issue(32'h8000_0000, 0);
    tick();
    tick();
    check("abort_in_mem", mem_req, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check("abort_ctrl", ctrl[9:1], rst_v[9:1]);
    check("abort_alu_op", alu_op, 0);
    check("abort_retired", retired, 0);
    check("abort_update_b", update_b, 0);
    model_reset();
    mem_ack = 1'b1;
    tick();
    resetn = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    check("abort_idle_ctrl", ctrl, cv(0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
    check("abort_no_retire", retired, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, instruction width; legal range 16..64.
REQ-002 SHALL have parameter ALUOP_W, default 5, ALU operation field width.
REQ-003 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on the rising edge.
REQ-005 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports instr_valid (input, 1) and instr_ready (output, 1), the instruction-fetch handshake.
REQ-007 SHALL have port instruction, input, INSTR_W, sampled on fetch handshake.
REQ-008 SHALL have ports mem_req (output, 1) and mem_ack (input, 1), the data-memory handshake.
REQ-009 SHALL have outputs branch, alu_src, mem_to_reg, reg_write and register_b (each 1), and alu_op (ALUOP_W).
REQ-010 SHALL have outputs mem_read_n and mem_write_n (each 1), active-low memory enables.
REQ-011 SHALL have outputs update_b (1), retired (CNT_W, count of completed instructions) and trap (1).

Function
REQ-012 SHALL decode the class from instruction[INSTR_W-1:INSTR_W-3]: 001 ALU, 100 memory, 010 constant, 000 NOP, 101 control transfer; all other values are illegal.
REQ-013 SHALL take alu_op for the ALU class from the ALUOP_W bits immediately below the class field; the function bit is F = instruction[INSTR_W-8].
REQ-014 SHALL implement states FETCH, DECODE, EXEC, MEM, WB and TRAP; resetn asserted forces FETCH.
REQ-015 FETCH: instr_ready=1; on instr_valid&instr_ready, register the instruction and go to DECODE; otherwise hold. instr_ready=0 in all other states.
REQ-016 DECODE: drive the registered control set for the class (one cycle), then go to EXEC.
REQ-017 EXEC: memory class goes to MEM; ALU and constant go to WB; NOP and beq retire and go to FETCH.
REQ-018 MEM: mem_req=1, held until mem_ack; load (F=0): mem_read_n=0; store (F=1): mem_write_n=0 and register_b=1. On mem_ack: load goes to WB, store retires and goes to FETCH.
REQ-019 WB: reg_write=1 for exactly one cycle, mem_to_reg=1 only for load; then retire and go to FETCH.
REQ-020 Retire SHALL increment retired (wrapping modulo 2^CNT_W) and toggle update_b, in the same cycle.
REQ-021 Beq (class 101 with the three bits below the class field = 001) SHALL assert branch=1, register_b=1 and alu_op=00010 during EXEC only; other control-transfer encodings are treated as NOP.
REQ-022 Memory and constant classes SHALL set alu_src=1 and alu_op=0. The constant class with the two bits at [INSTR_W-7:INSTR_W-8] not equal to 10 is treated as NOP.
REQ-023 mem_ack received outside MEM SHALL be ignored; instruction changes outside the handshake SHALL be ignored.
REQ-024 Minimum latency (handshake to retire): 3 cycles for NOP/beq, 4 for ALU/constant, 4+wait for store, 5+wait for load.

Reset
REQ-025 SHALL drive, while resetn=0: state FETCH, mem_read_n=1, mem_write_n=1, all other control outputs 0, alu_op=0, retired=0, update_b=0, trap=0, mem_req=0.
REQ-026 SHALL abort any in-flight access immediately when reset is asserted mid-MEM; no retire is counted.

Configuration
REQ-027 With ILLEGAL_TRAP_EN defined, an illegal class SHALL go from DECODE to TRAP, setting trap=1 and holding there (instr_ready=0) until reset.
REQ-028 Without ILLEGAL_TRAP_EN, an illegal class SHALL be treated as NOP, and trap SHALL be tied to 0.

Structure
REQ-029 SHALL place the class codes, state encoding, ALU opcode constants (including BEQ=00010) and reset control values in package control_pkg.
REQ-030 SHALL place the combinational class/function decode in sub-module control_decode; the FSM, counter and handshakes SHALL remain in control_fsm.

Verification
REQ-031 ALU add, instruction 0x20000000 with instr_valid=1 -> reg_write=1 in WB at cycle 4, alu_op=00000, retired=1, update_b=1.
REQ-032 Load 0x80000000 with mem_ack delayed by 3 cycles -> mem_read_n=0 and mem_req held for 3 cycles, then WB with mem_to_reg=1; mem_write_n stays 1 throughout.
REQ-033 Store 0x81000000 -> mem_write_n=0 and register_b=1 in MEM, reg_write never asserted, retired increments on mem_ack.
REQ-034 Beq 0xA4000000 -> branch=1 and alu_op=00010 for one cycle; retired increments.
REQ-035 Class 111 (0xE0000000): with ILLEGAL_TRAP_EN -> trap=1 and instr_ready=0 until resetn pulse; without it -> retired increments as for NOP.
REQ-036 With retired preloaded to 0xFFFF by 65535 NOPs, one further NOP -> retired=0x0000; resetn pulse in MEM -> all outputs at reset values within the same cycle.
